// File: rtl/shift_register_fifo_pro_pkg.sv
// Shared constants for the shift-register FIFO.
// Default geometry and occupancy-counter width derivation.
package shift_register_fifo_pro_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_register_fifo_pro_entry_reg.sv
// One FIFO storage slot: register with reset, clear and enable.
// Reset wins over clear, clear wins over enable.
import shift_register_fifo_pro_pkg::*;

module fifo_entry_reg #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_register_fifo_pro.sv
// Shift-register FIFO, first-word-fall-through, head at entry 0.
// Pops shift every entry toward the head; pushes land at the tail.
import shift_register_fifo_pro_pkg::*;

module shift_register_fifo_pro #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CNTWID  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNTWID-1:0] count,
  output logic              overflow,
  output logic              underflow
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL > DEPTH) begin : g_bad_ae
    $error("AE_LEVEL must not exceed DEPTH");
  end

  logic [DEPTH-1:0][WIDTH-1:0] q;
  logic [CNTWID-1:0]           count_q;
  logic [CNTWID-1:0]           wr_idx;
  logic                        push_acc;
  logic                        pop_acc;
  logic                        ovf_q;
  logic                        unf_q;

  assign empty        = (count_q == '0);
  assign full         = (int'(count_q) == DEPTH);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);
  assign count        = count_q;
  assign data_out     = q[0];
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign push_acc = push & (~full | pop);
  assign pop_acc  = pop & ~empty;
  // Tail slot after any same-cycle shift.
  assign wr_idx   = count_q - CNTWID'(pop_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNTWID'(push_acc)
                         - CNTWID'(pop_acc);
      if (push & full & ~pop) ovf_q <= 1'b1;
      if (pop & empty)        unf_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [WIDTH-1:0] shift_src;
    logic [WIDTH-1:0] d;

    if (i == DEPTH - 1) begin : g_top
      assign shift_src = '0;
    end else begin : g_mid
      assign shift_src = q[i+1];
    end

    always_comb begin
      d = q[i];
      if (pop_acc) d = shift_src;
      if (push_acc && wr_idx == CNTWID'(i))
        d = data_in;
    end

    fifo_entry_reg #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk(clk),
      .rst(rst),
      .clr(flush),
      .en (push_acc | pop_acc),
      .d  (d),
      .q  (q[i])
    );
  end

endmodule

// File: tb/tb_shift_register_fifo_pro.sv
// Bench for shift_register_fifo_pro: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_shift_register_fifo_pro;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst, flush, push, pop;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          empty, full, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mq[$];
  bit m_ovf, m_unf;

  shift_register_fifo_pro #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .empty(empty), .full(full),
    .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit f,
                       input bit pu, input bit po,
                       input logic [W-1:0] din);
    int n;
    n = mq.size();
    if (r) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else if (f) begin
      mq.delete();
    end else begin
      if (pu && n == D && !po) m_ovf = 1;
      if (po && n == 0) m_unf = 1;
      if (po && n > 0) void'(mq.pop_front());
      if (pu && (n < D || po)) mq.push_back(din);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    check("count", 32'(count), 32'(n));
    check("data_out", 32'(data_out),
          n > 0 ? 32'(mq[0]) : 32'd0);
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == D));
    check("almost_full", 32'(almost_full), 32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input bit r, input bit f,
                      input bit pu, input bit po,
                      input logic [W-1:0] din);
    rst = r; flush = f; push = pu; pop = po;
    data_in = din;
    @(posedge clk);
    model(r, f, pu, po, din);
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22;
    fill[2] = 8'h33; fill[3] = 8'h44;
    rst = 1; flush = 0; push = 0; pop = 0; data_in = '0;
    m_ovf = 0; m_unf = 0;

    step(1, 0, 0, 0, 8'h00);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout", 32'(data_out), 32'd0);

    // fill and drain
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, fill[i]);
    check("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("drain_head", 32'(data_out), 32'(fill[i]));
      step(0, 0, 0, 1, 8'h00);
    end
    check("drain_dout0", 32'(data_out), 32'd0);

    // overflow at full, then simultaneous at full
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, fill[i]);
    step(0, 0, 1, 0, 8'h55);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head", 32'(data_out), 32'h11);
    step(0, 0, 1, 1, 8'h55);
    check("full_sim_head", 32'(data_out), 32'h22);
    check("full_sim_cnt", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    check("ovf_after_flush", 32'(overflow), 32'd1);
    step(1, 0, 0, 0, 8'h00);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // overflow must stay clear on push+pop at full
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, fill[i]);
    step(0, 0, 1, 1, 8'h55);
    check("full_sim_noovf", 32'(overflow), 32'd0);
    step(1, 0, 0, 0, 8'h00);

    // push+pop while empty
    step(0, 0, 1, 1, 8'hA5);
    check("empty_sim_dout", 32'(data_out), 32'hA5);
    check("empty_sim_unf", 32'(underflow), 32'd1);

    // flush priority at count 3
    step(0, 0, 1, 0, 8'h01);
    step(0, 0, 1, 0, 8'h02);
    step(0, 1, 1, 1, 8'h77);
    check("flush_cnt", 32'(count), 32'd0);
    check("flush_unf", 32'(underflow), 32'd1);

    // reset mid-traffic
    step(0, 0, 1, 0, 8'h03);
    step(0, 0, 1, 0, 8'h04);
    step(1, 0, 1, 0, 8'h05);
    check("rst_mid_cnt", 32'(count), 32'd0);
    check("rst_mid_unf", 32'(underflow), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0,
           $urandom_range(59) == 0,
           $urandom_range(99) < 55,
           $urandom_range(99) < 45,
           W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_register_fifo_pro.md
SHIFT_REGISTER_FIFO_PRO -- requirements
Module: shift_register_fifo_pro

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width in bits (at least 1).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of entries (at least 2).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-1, meaning count at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 1, meaning count at or below which almost_empty asserts.
REQ-005 The block SHALL have derived constant CNTWID = clog2(DEPTH+1).
REQ-006 The block SHALL have port clk, input, 1 bit, meaning clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous, active-high.
REQ-008 The block SHALL have port flush, input, 1 bit, meaning synchronous discard of all stored entries.
REQ-009 The block SHALL have port push, input, 1 bit, meaning write request.
REQ-010 The block SHALL have port pop, input, 1 bit, meaning read request.
REQ-011 The block SHALL have port data_in, input, WIDTH bits, meaning write data.
REQ-012 The block SHALL have port data_out, output, WIDTH bits, meaning head entry.
REQ-013 The block SHALL have ports empty, full, almost_full and almost_empty, each output, 1 bit, meaning occupancy status.
REQ-014 The block SHALL have port count, output, CNTWID bits, meaning current occupancy.
REQ-015 The block SHALL have ports overflow and underflow, each output, 1 bit, meaning sticky error flags.

Function
REQ-016 The block SHALL define push_acc as push & (!full | pop) and pop_acc as pop & !empty.
REQ-017 On each cycle without rst or flush, count SHALL update to count + push_acc - pop_acc; count SHALL never exceed DEPTH or wrap below 0.
REQ-018 On pop_acc, every entry i SHALL load entry i+1 (shift toward the head), and the top vacated slot SHALL load 0.
REQ-019 On push_acc, data_in SHALL be written to index count - pop_acc, in the same cycle as any shift.
REQ-020 data_out SHALL equal entry 0 combinationally, which is 0 when empty; the first-write-to-data_out latency is 1 cycle (first-word-fall-through).
REQ-021 Status outputs SHALL be combinational from count: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-022 When push and pop occur while full, both SHALL be accepted, count SHALL stay DEPTH, and overflow SHALL not set.
REQ-023 When push and pop occur while empty, the push SHALL be accepted, count SHALL become 1, and underflow SHALL set.
REQ-024 When push occurs while full without pop, the push SHALL be dropped, the contents SHALL stay unchanged, and overflow SHALL set on the next edge.
REQ-025 When pop occurs while empty, the pop SHALL be ignored and underflow SHALL set on the next edge.
REQ-026 overflow and underflow SHALL remain set until rst; flush SHALL not clear them.
REQ-027 flush SHALL take priority over push and pop: count SHALL become 0, all entries SHALL become 0, and push and pop in that cycle SHALL be discarded with no flag update.
REQ-028 rst SHALL take priority over flush, push and pop.

Reset
REQ-029 On rst, count, all entries, overflow and underflow SHALL become 0 on the same edge.
REQ-030 After the reset edge, data_out=0, empty=1, full=0, almost_empty=1, and almost_full=(AF_LEVEL==0).
REQ-031 rst asserted mid-operation SHALL discard all contents without draining.

Structure
REQ-032 A shared package SHALL hold the default WIDTH and DEPTH and the clog2-based width derivation; the block SHALL have no typedefs beyond these.
REQ-033 A single sub-module, fifo_entry_reg, SHALL implement one WIDTH-bit register with synchronous reset, clear and enable, instantiated DEPTH times in a generate loop.
REQ-034 Elaboration SHALL fail if DEPTH<2, AF_LEVEL>DEPTH, or AE_LEVEL>DEPTH.

Verification
All scenarios use WIDTH=8, DEPTH=4, AF_LEVEL=3 and AE_LEVEL=1.
REQ-035 Fill and drain: push 0x11, 0x22, 0x33, 0x44 -> count 1..4, almost_full at count 3, full at 4; then pop x4 -> data_out shows 0x11, 0x22, 0x33, 0x44, then empty=1 and data_out=0.
REQ-036 Full overflow: at full, push 0x55 with no pop -> count stays 4, contents unchanged, overflow=1 next cycle; overflow still 1 after flush, cleared only by rst.
REQ-037 Full simultaneous: at full with 0x11 at the head, push 0x55 and pop -> count 4, data_out 0x22, 0x55 at tail, overflow stays 0.
REQ-038 Empty simultaneous: push 0xA5 and pop while empty -> count 1, data_out 0xA5 next cycle, underflow=1.
REQ-039 Flush priority: at count 3, assert flush with push 0x77 and pop -> count 0, data_out 0, flags unchanged.
REQ-040 Reset mid-traffic: at count 2 with underflow=1, assert rst while push=1 -> count 0, underflow 0, empty 1, and the push is discarded.
